// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline: base opcodes and the bit
// positions of the 7-bit control vector produced by the control decoder.
package rv_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Control vector layout: {ALUSrc,AddSrc,Branch,MemWrite,MemRead,MemtoReg,RegWrite}
  localparam int CTRL_W        = 7;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_ADDSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWRITE = 0;

endpackage : rv_pkg

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose
// destination is read by the instruction currently in ID.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       lu_hazard_o
);

  // rs2 is compared even for I-type instructions; a spurious stall is
  // cheaper than decoding the opcode here. x0 is never a real dependency.
  assign lu_hazard_o = ex_valid_i & ex_mem_read_i & id_valid_i &
                       (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and
// a saturating count of inserted load-use bubbles.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              stall_ifid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Everything EX needs from one instruction; an all-zero record is a bubble.
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic              funct7b5;
  } ex_rec_t;

  ex_rec_t          ex_q, ex_d, id_rec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hazard;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.ctrl[CTRL_MEMREAD]),
    .ex_rd_i       (ex_q.rd),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .lu_hazard_o   (lu_hazard)
  );

  // id_ctrl is taken as presented even when id_valid=0; the decoder already
  // clears it for non-instructions.
  assign id_rec = '{valid: id_valid, ctrl: id_ctrl, pc: id_pc,
                    rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                    rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    funct3: id_funct3, funct7b5: id_funct7b5};

  // A flush squashes the stall request: the dependent instruction is dead.
  assign stall_ifid = lu_hazard & ~flush;

  // Next-state selection in edge priority order: flush, hold, hazard, load.
  always_comb begin
    // NOTE: defaults first so every path assigns ex_d/cnt_d and no latch is inferred.
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (lu_hazard) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d = id_rec;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign bubble_cnt  = cnt_q;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a random
// run, all compared against an instruction-level reference model.
module tb_id_ex_stage;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [6:0] C_LOAD = 7'b1000111; // ALUSrc,MemRead,MemtoReg,RegWrite
  localparam logic [6:0] C_ADD  = 7'b0000001; // RegWrite

  logic clk = 1'b0;
  logic rst, flush, hold, id_valid;
  logic [6:0] id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic id_funct7b5;

  logic ex_valid, ex_funct7b5, stall_ifid;
  logic [6:0] ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [15:0] bubble_cnt;

  logic s_ex_valid, s_ex_funct7b5, s_stall_ifid;
  logic [6:0] s_ex_ctrl;
  logic [XLEN-1:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0] s_ex_funct3;
  logic [1:0] s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .stall_ifid(stall_ifid), .bubble_cnt(bubble_cnt));

  // Narrow-counter instance sharing the same stimulus, for saturation.
  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_pc(s_ex_pc),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
    .ex_funct7b5(s_ex_funct7b5), .stall_ifid(s_stall_ifid), .bubble_cnt(s_bubble_cnt));

  // ---------------- reference model (instruction level) ----------------
  typedef struct packed {
    logic valid; logic [6:0] ctrl;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0] rs1, rs2, rd; logic [2:0] f3; logic f7;
  } rec_t;

  rec_t m_ex;          // instruction the model says occupies EX
  int   m_cnt16, m_cnt2;

  function automatic rec_t dut_rec();
    return rec_t'({ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5});
  endfunction

  function automatic rec_t id_as_rec();
    return rec_t'({id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
                   id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5});
  endfunction

  // ID reads a nonzero register that the load in EX has not produced yet.
  function automatic bit model_dependency();
    if (!(m_ex.valid && m_ex.ctrl[CTRL_MEMREAD] && id_valid)) return 1'b0;
    if (m_ex.rd == 5'd0) return 1'b0;
    return (m_ex.rd == id_rs1) || (m_ex.rd == id_rs2);
  endfunction

  function automatic bit model_stall();
    return model_dependency() && !flush;
  endfunction

  // One clock edge: DUT and model advance together.
  task automatic step();
    bit dep;
    rec_t id_now;
    dep    = model_dependency();
    id_now = id_as_rec();
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_ex = '0;
    end else if (hold) begin
      m_ex = m_ex;
    end else if (dep) begin
      m_ex = '0;
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end else begin
      m_ex = id_now;
    end
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [6:0] ctrl, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [XLEN-1:0] pc);
    id_valid = v; id_ctrl = ctrl; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_pc = pc;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_instr(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      step();
    end
    checks++;
    if (dut_rec() !== rec_t'('0)) begin
      failures++; $display("FAIL reset_ex got=%h want=0", dut_rec());
    end
    checks++;
    if (bubble_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d want=0", bubble_cnt);
    end
    checks++;
    if (stall_ifid !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b want=0", stall_ifid);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    reset_dut();
    set_instr(1'b1, C_LOAD, 5'd5, 5'd2, 5'd0, 32'h200);   // lw x5,0(x2)
    step();
    set_instr(1'b1, C_ADD, 5'd6, 5'd5, 5'd7, 32'h204);    // add x6,x5,x7
    checks++;
    if (stall_ifid !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b want=1", stall_ifid);
    end
    step();
    checks++;
    if ({ex_valid, ex_ctrl, bubble_cnt} !== {1'b0, 7'd0, 16'd1}) begin
      failures++; $display("FAIL lu_bubble got v=%b c=%h n=%0d want v=0 c=0 n=1",
                           ex_valid, ex_ctrl, bubble_cnt);
    end
    checks++;
    if (stall_ifid !== 1'b0) begin
      failures++; $display("FAIL lu_release got=%b want=0", stall_ifid);
    end
    step();
    checks++;
    if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd6, 32'h204}) begin
      failures++; $display("FAIL lu_enter got v=%b rd=%0d pc=%h want v=1 rd=6 pc=204",
                           ex_valid, ex_rd, ex_pc);
    end
  endtask

  task automatic test_x0_load();
    reset_dut();
    set_instr(1'b1, C_LOAD, 5'd0, 5'd3, 5'd0, 32'h300);   // lw x0
    step();
    set_instr(1'b1, C_ADD, 5'd6, 5'd0, 5'd0, 32'h304);    // add x6,x0,x0
    checks++;
    if (stall_ifid !== 1'b0) begin
      failures++; $display("FAIL x0_stall got=%b want=0", stall_ifid);
    end
    step();
    checks++;
    if ({ex_valid, ex_pc, bubble_cnt} !== {1'b1, 32'h304, 16'd0}) begin
      failures++; $display("FAIL x0_pass got v=%b pc=%h n=%0d want v=1 pc=304 n=0",
                           ex_valid, ex_pc, bubble_cnt);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    set_instr(1'b1, C_LOAD, 5'd9, 5'd1, 5'd0, 32'h400);
    step();
    set_instr(1'b1, C_ADD, 5'd4, 5'd1, 5'd9, 32'h404);    // rs2 depends
    flush = 1'b1; #1;
    checks++;
    if (stall_ifid !== 1'b0) begin
      failures++; $display("FAIL flush_stall got=%b want=0", stall_ifid);
    end
    step();
    flush = 1'b0;
    checks++;
    if ({ex_valid, ex_ctrl, bubble_cnt} !== {1'b0, 7'd0, 16'd0}) begin
      failures++; $display("FAIL flush_bubble got v=%b c=%h n=%0d want v=0 c=0 n=0",
                           ex_valid, ex_ctrl, bubble_cnt);
    end
  endtask

  task automatic test_hold();
    rec_t frozen;
    reset_dut();
    set_instr(1'b1, C_LOAD, 5'd8, 5'd1, 5'd2, 32'h100);
    step();
    frozen = m_ex;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, C_ADD, 5'd3, 5'd8, 5'd2, 32'h500 + 32'(4 * i));  // depends on x8
      checks++;
      if (stall_ifid !== 1'b1) begin
        failures++; $display("FAIL hold_stall[%0d] got=%b want=1", i, stall_ifid);
      end
      step();
      checks++;
      if (dut_rec() !== frozen || bubble_cnt !== 16'd0) begin
        failures++; $display("FAIL hold_frozen[%0d] got pc=%h n=%0d want pc=100 n=0",
                             i, ex_pc, bubble_cnt);
      end
    end
    hold = 1'b0;
    set_instr(1'b1, C_ADD, 5'd3, 5'd4, 5'd2, 32'h600);    // independent
    step();
    checks++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h600}) begin
      failures++; $display("FAIL hold_release got v=%b pc=%h want v=1 pc=600", ex_valid, ex_pc);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      set_instr(1'b1, C_LOAD, 5'd5, 5'd1, 5'd0, 32'h700 + 32'(16 * k));
      step();
      set_instr(1'b1, C_ADD, 5'd6, 5'd5, 5'd7, 32'h704 + 32'(16 * k));
      step();
      checks++;
      if (s_bubble_cnt !== 2'((k + 1 > 3) ? 3 : k + 1) || bubble_cnt !== 16'(k + 1)) begin
        failures++; $display("FAIL b2b_cnt[%0d] got sat=%0d wide=%0d want sat=%0d wide=%0d",
                             k, s_bubble_cnt, bubble_cnt, (k + 1 > 3) ? 3 : k + 1, k + 1);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    set_instr(1'b1, C_LOAD, 5'd10, 5'd1, 5'd0, 32'h800);
    step();
    set_instr(1'b1, C_ADD, 5'd11, 5'd10, 5'd10, 32'h804);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    checks++;
    if (dut_rec() !== rec_t'('0) || bubble_cnt !== 16'd0 || stall_ifid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_stall got ex=%h n=%0d st=%b want all 0",
                           dut_rec(), bubble_cnt, stall_ifid);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(63) == 0);
      flush = ($urandom_range(7) == 0);
      hold  = ($urandom_range(5) == 0);
      set_instr($urandom_range(3) != 0,
                ($urandom_range(1) == 0) ? C_LOAD : 7'($urandom),
                5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                $urandom);
      checks++;
      if (stall_ifid !== model_stall() || s_stall_ifid !== model_stall()) begin
        failures++; $display("FAIL rnd_stall[%0d] got=%b/%b want=%b",
                             i, stall_ifid, s_stall_ifid, model_stall());
      end
      step();
      checks++;
      if (dut_rec() !== m_ex) begin
        failures++; $display("FAIL rnd_ex[%0d] got=%h want=%h", i, dut_rec(), m_ex);
      end
      checks++;
      if (bubble_cnt !== 16'(m_cnt16) || s_bubble_cnt !== 2'(m_cnt2)) begin
        failures++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                             i, bubble_cnt, s_bubble_cnt, m_cnt16, m_cnt2);
      end
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    m_ex = '0; m_cnt16 = 0; m_cnt2 = 0;
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    set_instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, '0);
    test_reset();
    test_load_use();
    test_x0_load();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_id_ex_stage
